// File: rtl/prover_shuffle_pkg.sv
// Shared types and index helpers for the multi-copy V shuffler.
// The element width F_NBITS mirrors the prover's field definition width.
package prover_shuffle_pkg;

    // Width of one field element as carried through the shuffler.
    localparam int F_NBITS = 64;

    // Direction of a shuffle step.
    typedef enum logic {
        UNSHUF = 1'b0,
        SHUF   = 1'b1
    } shuf_mode_t;

    // Control FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } shuf_state_t;

    // Kind of operation in flight, decides what completion commits.
    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_STEP = 1'b1
    } shuf_op_t;

    // Rotate a w-bit index left by one position.
    function automatic int unsigned rotl_idx(input int unsigned idx, input int unsigned w);
        int unsigned mask;
        if (w <= 1) begin
            return idx;
        end
        mask = (32'd1 << w) - 32'd1;
        return ((idx << 1) | (idx >> (w - 1))) & mask;
    endfunction

    // Rotate a w-bit index right by one position.
    function automatic int unsigned rotr_idx(input int unsigned idx, input int unsigned w);
        int unsigned mask;
        if (w <= 1) begin
            return idx;
        end
        mask = (32'd1 << w) - 32'd1;
        return ((idx >> 1) | (idx << (w - 1))) & mask;
    endfunction

    // Reverse the bit order of a w-bit index.
    function automatic int unsigned bitrev_idx(input int unsigned idx, input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned b = 0; b < w; b++) begin
            r = r | (((idx >> b) & 32'd1) << (w - 1 - b));
        end
        return r;
    endfunction

endpackage

// File: rtl/prover_shuffle_v_perm.sv
// Combinational one-copy index-rotation permute.
// UNSHUF: out[j] = in[rotl(j)];  SHUF: out[j] = in[rotr(j)].
// Pure wiring plus a 2:1 mux per element; values are never modified.
module prover_shuffle_v_perm
    import prover_shuffle_pkg::*;
#(
    parameter int nInBits = 4,
    parameter int W       = F_NBITS
) (
    input  shuf_mode_t   mode,
    input  logic [W-1:0] arr_in  [1 << nInBits],
    output logic [W-1:0] arr_out [1 << nInBits]
);

    localparam int NG = 1 << nInBits;

    // Each output element picks one of two fixed source positions.
    for (genvar j = 0; j < NG; j++) begin : g_el
        localparam int unsigned SRC_L = rotl_idx(unsigned'(j), unsigned'(nInBits));
        localparam int unsigned SRC_R = rotr_idx(unsigned'(j), unsigned'(nInBits));
        assign arr_out[j] = (mode == SHUF) ? arr_in[SRC_R] : arr_in[SRC_L];
    end

endmodule

// File: rtl/prover_shuffle_v_multi.sv
// Multi-copy bidirectional V shuffler for the sumcheck prover.
// Holds nCopies arrays of 2^nInBits elements; each accepted step rotates
// the element index of every copy by one bit (left = UNSHUF, right = SHUF).
// Loads and steps take plstages cycles; results are staged in a shadow
// array and committed to v_out only on the completion edge.
// Optional feature macro: PROVER_SHUFFLE_V_BITREV_EN adds a 'bitrev' input
// that loads each copy in bit-reversed index order.
module prover_shuffle_v_multi
    import prover_shuffle_pkg::*;
#(
    parameter  int nInBits  = 4,
    parameter  int nCopies  = 2,
    parameter  int plstages = 2,
    localparam int ngates   = 1 << nInBits,
    localparam int TOT      = nCopies * ngates,
    localparam int RND_W    = $clog2(nInBits + 1)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic               restart,
    input  logic               mode,
`ifdef PROVER_SHUFFLE_V_BITREV_EN
    input  logic               bitrev,
`endif
    input  logic [F_NBITS-1:0] v_in  [TOT],
    output logic               ready,
    output logic               ready_pulse,
    output logic [RND_W-1:0]   round,
    output logic [F_NBITS-1:0] v_out [TOT]
);

    localparam int CNT_W = (plstages > 1) ? $clog2(plstages) : 1;

    shuf_state_t        state_q, state_d;
    shuf_op_t           op_q, op_d;
    shuf_mode_t         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               pulse_q, pulse_d;

    logic [F_NBITS-1:0] shadow_q [TOT];
    logic [F_NBITS-1:0] shadow_d [TOT];
    logic [F_NBITS-1:0] v_out_q  [TOT];
    logic [F_NBITS-1:0] v_out_d  [TOT];

    logic [F_NBITS-1:0] perm_arr [TOT];
    logic [F_NBITS-1:0] load_arr [TOT];

    // Per-copy permute of the committed contents, and the load mapping.
    for (genvar c = 0; c < nCopies; c++) begin : g_copy
        logic [F_NBITS-1:0] cp_in  [ngates];
        logic [F_NBITS-1:0] cp_out [ngates];

        for (genvar j = 0; j < ngates; j++) begin : g_map
            localparam int unsigned BR = bitrev_idx(unsigned'(j), unsigned'(nInBits));
            assign cp_in[j]              = v_out_q[c*ngates + j];
            assign perm_arr[c*ngates + j] = cp_out[j];
`ifdef PROVER_SHUFFLE_V_BITREV_EN
            assign load_arr[c*ngates + j] = bitrev ? v_in[c*ngates + int'(BR)]
                                                   : v_in[c*ngates + j];
`else
            // Bit-reversed loading is compiled out; BR is kept for parity.
            if (BR > unsigned'(ngates)) begin : g_never
            end
            assign load_arr[c*ngates + j] = v_in[c*ngates + j];
`endif
        end

        prover_shuffle_v_perm #(
            .nInBits (nInBits),
            .W       (F_NBITS)
        ) u_perm (
            .mode    (shuf_mode_t'(mode)),
            .arr_in  (cp_in),
            .arr_out (cp_out)
        );
    end

    // Next-state logic: accept restart/en, count stages, commit on completion.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        round_d  = round_q;
        pulse_d  = 1'b0;
        shadow_d = shadow_q;
        v_out_d  = v_out_q;

        if (restart) begin
            // Restart wins over en and aborts anything in flight.
            shadow_d = load_arr;
            op_d     = OP_LOAD;
            cnt_d    = '0;
            state_d  = ST_BUSY;
        end else if (state_q == ST_IDLE) begin
            if (en) begin
                // v_out_q is stable while idle, so the permute is taken now.
                shadow_d = perm_arr;
                op_d     = OP_STEP;
                mode_d   = shuf_mode_t'(mode);
                cnt_d    = '0;
                state_d  = ST_BUSY;
            end
        end else begin
            if (cnt_q == CNT_W'(plstages - 1)) begin
                v_out_d = shadow_q;
                pulse_d = 1'b1;
                state_d = ST_IDLE;
                if (op_q == OP_LOAD) begin
                    round_d = '0;
                end else if (mode_q == UNSHUF) begin
                    round_d = (round_q == RND_W'(nInBits - 1)) ? '0 : round_q + 1'b1;
                end else begin
                    round_d = (round_q == '0) ? RND_W'(nInBits - 1) : round_q - 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            mode_q  <= UNSHUF;
            cnt_q   <= '0;
            round_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            pulse_q <= pulse_d;
        end
    end

    // Data arrays: shadow holds the pending result, v_out the committed one.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < TOT; i++) begin
                shadow_q[i] <= '0;
                v_out_q[i]  <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            v_out_q  <= v_out_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign ready_pulse = pulse_q;
    assign round       = round_q;
    assign v_out       = v_out_q;

endmodule

// File: doc/prover_shuffle_v_multi.md
# prover_shuffle_v_multi

Multi-copy, bidirectional successor to the single-array V shuffler in the sumcheck prover. Holds `nCopies` arrays of `2^nInBits` field elements. Each enabled step permutes every array by a one-bit index rotation, in a direction selected per step, so that each sumcheck round finds its operand pairs adjacent. Sits between the layer evaluator (which supplies `v_in`) and the per-round prover cores; step completion is signalled with `ready`/`ready_pulse`, and a round counter is exported.

## Interface
- `nInBits`, default 4: index width; `ngates = 1 << nInBits`; legal values 1 and up.
- `nCopies`, default 2: number of independent arrays shuffled in lockstep; legal values 1 and up.
- `plstages`, default 2: cycles per load or step; legal values 1 and up.
- `clk` in 1: single clock, rising edge.
- `rstb` in 1: asynchronous, active-low reset.
- `en` in 1: request one shuffle step; honoured only while idle.
- `restart` in 1: load `v_in` and zero the round counter; has priority over `en`.
- `mode` in 1: sampled with `en`; 0 = UNSHUF, 1 = SHUF.
- `v_in` in `F_NBITS` x `nCopies*ngates` (unpacked): copy c, element j is at index `c*ngates+j`.
- `ready` out 1: idle; `v_out` is stable and valid.
- `ready_pulse` out 1: one-cycle strobe on each load/step completion.
- `round` out `$clog2(nInBits+1)`: number of completed net steps modulo `nInBits`.
- `v_out` out `F_NBITS` x `nCopies*ngates`: current array contents, same layout as `v_in`.

## Operation
- FSM states:
  - IDLE: `ready`=1.
  - BUSY: count `plstages` cycles, then return to IDLE.
- Transitions out of IDLE:
  - `restart`=1: capture `v_in` into a shadow register, set `round`=0, go to BUSY.
  - Else `en`=1: capture `mode`, compute the permuted array, go to BUSY.
- Step permutation, applied to each copy independently with identical indexing:
  - UNSHUF: `v_next[j] = v[rotl(j)]`.
  - SHUF: `v_next[j] = v[rotr(j)]`.
  - `rotl`/`rotr` rotate the `nInBits`-bit index by one position.
- `round` update per completed step:
  - UNSHUF: +1, wrapping `nInBits-1` to 0.
  - SHUF: -1, wrapping 0 to `nInBits-1`.
  - After `nInBits` UNSHUF steps, arrays equal the loaded values and `round`=0.
- `nInBits`=1: both permutations are identity; `round` stays 0.
- Values are moved only, never modified; no field arithmetic is performed.
- `restart` while BUSY: abort the in-flight step, reload from `v_in`, restart the `plstages` count. The aborted step never updates `v_out` or `round`.
- `en` while BUSY (without `restart`): ignored, not queued.
- `en`=1 and `restart`=1 in the same cycle: restart only.
- `mode` is a don't-care except in the cycle `en` is accepted.

## Timing
- Reset values: `ready`=1, `ready_pulse`=0, `round`=0, all `v_out`=0, FSM in IDLE.
- Request accepted at edge T: `ready` falls after T.
- At edge T+`plstages`: `v_out` and `round` update, `ready` rises, `ready_pulse`=1 for exactly that cycle.
- Back-to-back operation: with `en` driven from registered `ready_pulse`, one step completes every `plstages`+1 cycles.
- `v_out` changes only on completion edges or on reset.
- Reset deassertion mid-BUSY: block is in IDLE with reset values; no `ready_pulse` is issued.

## Configuration
- `PROVER_SHUFFLE_V_BITREV_EN` defined:
  - Adds input `bitrev` (1 bit), sampled with `restart`.
  - `bitrev`=1 loads `v[j] = v_in[bitreverse(j)]` per copy.
  - `bitrev`=0 loads unchanged.
- Macro undefined: no `bitrev` port; loads are always unchanged; RTL is otherwise identical.

## Structure
- Package `prover_shuffle_pkg` holds:
  - `shuf_mode_t` enum (UNSHUF=0, SHUF=1).
  - FSM state enum.
  - Functions `rotl_idx`, `rotr_idx`, `bitrev_idx` (parameterised by width).
- Sub-module `prover_shuffle_v_perm`: combinational one-copy permute (`mode` in, array in, array out), instantiated `nCopies` times.
- Top level holds the FSM, the `plstages` counter, and the register arrays.
- `F_NBITS` comes from the shared field definitions header.

## Test plan
All scenarios use `nInBits`=4, `nCopies`=2, `plstages`=2. Copy c is loaded with `v_in[c*16+j] = 16*c + j`.

1. Reset, then `restart`: `ready` low for 2 cycles; then `ready_pulse` once, `v_out` equals `v_in`, `round`=0.
2. One UNSHUF step: `v_out[1]`=2, `v_out[8]`=1, `v_out[15]`=15, `v_out[16+1]`=18, `round`=1.
3. Four chained UNSHUF steps (`en` <= `ready_pulse`): `v_out` equals `v_in`, `round`=0, exactly 4 `ready_pulse`s.
4. UNSHUF then SHUF: `v_out` equals `v_in`, `round`=0; from `round`=0, a SHUF step gives `round`=3 and `v_out[1]`=8.
5. `en` pulsed while BUSY: ignored, no extra pulse. `restart` one cycle after `en`: no step result appears, `v_out` equals `v_in` at completion. `en`+`restart` together: restart only.
6. `rstb` asserted mid-BUSY: `v_out`=0, `ready`=1, `round`=0 immediately. With `PROVER_SHUFFLE_V_BITREV_EN` and `bitrev`=1: `v_out[1]`=8, `v_out[3]`=12.
